// File: rtl/systolic_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_feeder_pkg: shared constants for the systolic array feeder.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package systolic_feeder_pkg;

  localparam int N_DEFAULT = 8;

  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_READ   = 3'd4;

  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

  function automatic int stream_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int drain_len(input int n);
    return n;
  endfunction

  function automatic int read_len(input int n);
    return n + 1;
  endfunction

  localparam int STREAM_LEN = stream_len(N_DEFAULT);
  localparam int DRAIN_LEN  = drain_len(N_DEFAULT);
  localparam int READ_LEN   = read_len(N_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/sysfeed_skew_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sysfeed_skew_sel: diagonal wavefront selector, lane k = M[k][t-k].         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sysfeed_skew_sel
  import systolic_feeder_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N*N-1:0]          i_mat,
  input  logic [cnt_width(N)-1:0] i_t,
  output logic [N-1:0]            o_lanes
);

  localparam int CW = cnt_width(N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam logic [CW:0] c_LO = (CW+1)'(k);
    logic [N-1:0] w_row;
    logic [CW:0]  w_diff;
    logic         w_in_window;

    assign w_row  = i_mat[k*N +: N];
    // One extra bit so t < k shows up as a borrow rather than a wrap.
    assign w_diff = {1'b0, i_t} - c_LO;
    assign w_in_window = !w_diff[CW] && (w_diff[CW-1:0] < CW'(N));
    assign o_lanes[k]  = w_in_window && w_row[w_diff[IW-1:0]];
  end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_feeder: loads A/B bit matrices and streams them skewed into the   |
// | OR-AND systolic array, then drains and reads out. Option:                  |
// | SYSFEED_AUTOSTART_EN skips ARMED. Rev 1.0                                  |
// +----------------------------------------------------------------------------+
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         start,
  output logic [N-1:0] a_lanes,
  output logic [N-1:0] b_lanes,
  output logic         readout,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] c_LAST_ROW   = CW'(2*N - 1);
  localparam logic [CW-1:0] c_STREAM_END = CW'(stream_len(N) - 1);
  localparam logic [CW-1:0] c_DRAIN_END  = CW'(drain_len(N) - 1);
  localparam logic [CW-1:0] c_READ_END   = CW'(read_len(N) - 1);

  logic [2:0]     r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [N*N-1:0] r_a, r_b, w_bt;
  logic [N-1:0]   w_a_sel, w_b_sel;
  logic [N-1:0]   r_a_lanes, r_b_lanes;
  logic           r_readout, r_busy, r_done, r_in_ready;
  logic           w_xfer;

  assign w_xfer = in_valid && r_in_ready && (r_state == ST_LOAD);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_LOAD: begin
        if (w_xfer) begin
          if (r_cnt == c_LAST_ROW) begin
            w_cnt_nxt = '0;
`ifdef SYSFEED_AUTOSTART_EN
            w_state_nxt = ST_STREAM;
`else
            w_state_nxt = ST_ARMED;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_ARMED: begin
`ifdef SYSFEED_AUTOSTART_EN
        w_state_nxt = ST_STREAM;
`else
        if (start) w_state_nxt = ST_STREAM;
`endif
      end
      ST_STREAM: begin
        if (r_cnt == c_STREAM_END) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == c_DRAIN_END) begin
          w_state_nxt = ST_READ;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_READ: begin
        if (r_cnt == c_READ_END) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
    if (!ena) begin
      w_state_nxt = ST_LOAD;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Row counter doubles as the load address: rows 0..N-1 fill A, N..2N-1 fill B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (ena && w_xfer) begin
      for (int r = 0; r < N; r++) begin
        if (r_cnt == CW'(r))     r_a[r*N +: N] <= in_data;
        if (r_cnt == CW'(r + N)) r_b[r*N +: N] <= in_data;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_tr_row
    for (genvar j = 0; j < N; j++) begin : g_tr_col
      assign w_bt[j*N + i] = r_b[i*N + j];
    end
  end

  sysfeed_skew_sel #(.N(N)) u_sel_a (
    .i_mat   (r_a),
    .i_t     (r_cnt),
    .o_lanes (w_a_sel)
  );

  sysfeed_skew_sel #(.N(N)) u_sel_b (
    .i_mat   (w_bt),
    .i_t     (r_cnt),
    .o_lanes (w_b_sel)
  );

  // in_ready follows the next state so it never advertises a slot the FSM has left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_lanes  <= '0;
      r_b_lanes  <= '0;
      r_readout  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (!ena) begin
      r_a_lanes  <= '0;
      r_b_lanes  <= '0;
      r_readout  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_a_lanes  <= (r_state == ST_STREAM) ? w_a_sel : '0;
      r_b_lanes  <= (r_state == ST_STREAM) ? w_b_sel : '0;
      r_readout  <= (r_state == ST_READ);
      r_busy     <= (r_state == ST_STREAM) || (r_state == ST_DRAIN) || (r_state == ST_READ);
      r_done     <= (r_state == ST_READ) && (r_cnt == c_READ_END);
      r_in_ready <= (w_state_nxt == ST_LOAD);
    end
  end

  assign a_lanes  = r_a_lanes;
  assign b_lanes  = r_b_lanes;
  assign readout  = r_readout;
  assign busy     = r_busy;
  assign done     = r_done;
  assign in_ready = r_in_ready;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_systolic_feeder: table-driven and randomized bench for systolic_feeder. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_systolic_feeder;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       start = 1'b0;
  logic       in_ready, readout, busy, done;
  logic [7:0] a_lanes, b_lanes;

  int n_checks = 0;
  int n_errors = 0;

  systolic_feeder #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .start    (start),
    .a_lanes  (a_lanes),
    .b_lanes  (b_lanes),
    .readout  (readout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      a;
    logic [63:0]      b;
    int               gap;
    logic [14:0][7:0] ea;
    logic [14:0][7:0] eb;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: cell (i,j) must see A[i][k] on lane i and B[k][j] on lane j at step i+j+k.
  function automatic logic [7:0] mdl_a(input logic [63:0] a, input int t);
    logic [7:0] r = '0;
    for (int k = 0; k < N; k++) begin
      int j = t - k;
      if (j >= 0 && j < N) r[k] = a[k*N + j];
    end
    return r;
  endfunction

  function automatic logic [7:0] mdl_b(input logic [63:0] b, input int t);
    logic [7:0] r = '0;
    for (int k = 0; k < N; k++) begin
      int i = t - k;
      if (i >= 0 && i < N) r[k] = b[i*N + k];
    end
    return r;
  endfunction

  task automatic load_all(input logic [63:0] a, input logic [63:0] b, input int gap,
                          input int start_after, input bit start_on_last);
    for (int r = 0; r < 2*N; r++) begin
      in_valid = 1'b1;
      in_data  = (r < N) ? a[r*N +: N] : b[(r-N)*N +: N];
      start    = start_on_last && (r == 2*N-1);
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      if (r == start_after) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_load_ready", in_ready, 1'b1);
        chk("start_in_load_busy", busy, 1'b0);
      end
      if (r != 2*N-1) repeat (gap) tick();
    end
  endtask

  // Timeline relative to the edge that enters STREAM (cycle 0).
  task automatic run_check(input logic [14:0][7:0] ea, input logic [14:0][7:0] eb);
`ifndef SYSFEED_AUTOSTART_EN
    chk("armed_ready", in_ready, 1'b0);
    chk("armed_busy", busy, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
`endif
    chk("c0_busy", busy, 1'b0);
    chk("c0_a_lanes", a_lanes, 8'h00);
    for (int n = 1; n <= 34; n++) begin
      tick();
      chk("a_lanes", a_lanes, (n <= 15) ? ea[n-1] : 8'h00);
      chk("b_lanes", b_lanes, (n <= 15) ? eb[n-1] : 8'h00);
      chk("busy", busy, (n <= 32));
      chk("readout", readout, (n >= 24 && n <= 32));
      chk("done", done, (n == 32));
      chk("in_ready", in_ready, (n >= 32));
    end
  endtask

  function automatic logic [14:0][7:0] seq_a(input logic [63:0] a);
    logic [14:0][7:0] s;
    for (int t = 0; t < 15; t++) s[t] = mdl_a(a, t);
    return s;
  endfunction

  function automatic logic [14:0][7:0] seq_b(input logic [63:0] b);
    logic [14:0][7:0] s;
    for (int t = 0; t < 15; t++) s[t] = mdl_b(b, t);
    return s;
  endfunction

  initial begin
    logic [63:0] ra, rb;

    for (int r = 0; r < N; r++) begin
      tbl[0].a[r*N +: N] = 8'(1 << r);
      tbl[0].b[r*N +: N] = 8'(1 << r);
    end
    tbl[0].gap = 0;
    tbl[0].ea  = {8'h80,8'h00,8'h40,8'h00,8'h20,8'h00,8'h10,8'h00,
                  8'h08,8'h00,8'h04,8'h00,8'h02,8'h00,8'h01};
    tbl[0].eb  = tbl[0].ea;
    tbl[1].a   = {64{1'b1}};
    tbl[1].b   = {64{1'b1}};
    tbl[1].gap = 0;
    tbl[1].ea  = {8'h80,8'hC0,8'hE0,8'hF0,8'hF8,8'hFC,8'hFE,8'hFF,
                  8'h7F,8'h3F,8'h1F,8'h0F,8'h07,8'h03,8'h01};
    tbl[1].eb  = tbl[1].ea;
    for (int i = 2; i < 6; i++) begin
      tbl[i].a   = {$urandom, $urandom};
      tbl[i].b   = {$urandom, $urandom};
      tbl[i].gap = (i == 2) ? 1 : int'($urandom_range(0, 2));
      tbl[i].ea  = seq_a(tbl[i].a);
      tbl[i].eb  = seq_b(tbl[i].b);
    end

    #12;
    chk("rst_a_lanes", a_lanes, 8'h00);
    chk("rst_b_lanes", b_lanes, 8'h00);
    chk("rst_readout", readout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      load_all(tbl[i].a, tbl[i].b, tbl[i].gap, -1, 1'b0);
      chk("ready_after_16", in_ready, 1'b0);
`ifndef SYSFEED_AUTOSTART_EN
      if (i == 2) begin
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        tick();
        in_valid = 1'b0;
        chk("armed_drop_ready", in_ready, 1'b0);
      end
`endif
      run_check(tbl[i].ea, tbl[i].eb);
    end

`ifndef SYSFEED_AUTOSTART_EN
    // start mid-load and on the final transfer must both be ignored.
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    load_all(ra, rb, 0, 4, 1'b1);
    repeat (3) begin
      tick();
      chk("armed_hold_busy", busy, 1'b0);
      chk("armed_hold_ready", in_ready, 1'b0);
    end
    run_check(seq_a(ra), seq_b(rb));
`endif

    // Asynchronous reset during STREAM step 4.
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    load_all(ra, rb, 0, -1, 1'b0);
`ifndef SYSFEED_AUTOSTART_EN
    start = 1'b1;
    tick();
    start = 1'b0;
`endif
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("pre_rst_a_lanes", a_lanes, mdl_a(ra, n-1));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", a_lanes, 8'h00);
    chk("async_rst_b", b_lanes, 8'h00);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", in_ready, 1'b1);
    repeat (3) begin
      tick();
      chk("rst_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    load_all(ra, rb, 0, -1, 1'b0);
    run_check(seq_a(ra), seq_b(rb));

    // ena low mid-LOAD must clear the row counter.
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    ena = 1'b0;
    tick();
    ena = 1'b1;
    chk("ena_load_ready", in_ready, 1'b1);
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    load_all(ra, rb, 0, -1, 1'b0);
    run_check(seq_a(ra), seq_b(rb));

    // ena low in DRAIN: back to LOAD with no done.
    load_all(ra, rb, 0, -1, 1'b0);
`ifndef SYSFEED_AUTOSTART_EN
    start = 1'b1;
    tick();
    start = 1'b0;
`endif
    repeat (18) tick();
    ena = 1'b0;
    tick();
    ena = 1'b1;
    chk("ena_drain_busy", busy, 1'b0);
    chk("ena_drain_ready", in_ready, 1'b1);
    chk("ena_drain_lanes", a_lanes, 8'h00);
    repeat (12) begin
      tick();
      chk("ena_no_done", done, 1'b0);
    end
    rb = {$urandom, $urandom};
    load_all(tbl[1].a, rb, 1, -1, 1'b0);
    run_check(tbl[1].ea, seq_b(rb));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
